// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
// Turns the PS/2 set-2 byte stream into a held-key vector for the 29
// piano-mapped keys. It also emits one-cycle press/release events for the
// recorder/playback FSM.
// Optional build macro: KEY_TRACKER_REPEAT_FILTER_EN
//   defined   -> a press of a key that is already held produces no event,
//                and a release of a key that is already clear produces no event
//   undefined -> every mapped make/break produces an event
// key_state behaves the same way in both builds.
module ps2_key_tracker #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic [7:0]  ps2_byte,
  input  logic        ps2_byte_valid,
  output logic [28:0] key_state,
  output logic        key_event_valid,
  output logic [4:0]  key_event_index,
  output logic        key_event_pressed,
  output logic        seq_error
);

  // Sequence decoder states
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_BREAK     = 2'd1;
  localparam logic [1:0] ST_EXT       = 2'd2;
  localparam logic [1:0] ST_EXT_BREAK = 2'd3;

  localparam logic [7:0] CODE_BREAK     = 8'hF0;
  localparam logic [7:0] CODE_EXTENDED  = 8'hE0;
  localparam logic [7:0] CODE_SELF_TEST = 8'hAA;
  localparam logic [7:0] CODE_ERR_LOW   = 8'h00;
  localparam logic [7:0] CODE_ERR_HIGH  = 8'hFF;

  // The counter value during the last idle cycle that is still allowed
  // before the pending prefix is abandoned.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

`ifdef KEY_TRACKER_REPEAT_FILTER_EN
  localparam logic REPEAT_FILTER = 1'b1;
`else
  localparam logic REPEAT_FILTER = 1'b0;
`endif

  // Map a set-2 make code to {hit, index}. Unmapped codes return hit = 0.
  function automatic logic [5:0] key_lookup(input logic [7:0] code);
    logic [5:0] res;
    case (code)
      8'h45:   res = {1'b1, 5'd0};
      8'h16:   res = {1'b1, 5'd1};
      8'h1E:   res = {1'b1, 5'd2};
      8'h26:   res = {1'b1, 5'd3};
      8'h25:   res = {1'b1, 5'd4};
      8'h2E:   res = {1'b1, 5'd5};
      8'h36:   res = {1'b1, 5'd6};
      8'h3D:   res = {1'b1, 5'd7};
      8'h3E:   res = {1'b1, 5'd8};
      8'h46:   res = {1'b1, 5'd9};
      8'h0E:   res = {1'b1, 5'd10};
      8'h4E:   res = {1'b1, 5'd11};
      8'h55:   res = {1'b1, 5'd12};
      8'h66:   res = {1'b1, 5'd13};
      8'h0D:   res = {1'b1, 5'd14};
      8'h15:   res = {1'b1, 5'd15};
      8'h1D:   res = {1'b1, 5'd16};
      8'h24:   res = {1'b1, 5'd17};
      8'h2D:   res = {1'b1, 5'd18};
      8'h2C:   res = {1'b1, 5'd19};
      8'h35:   res = {1'b1, 5'd20};
      8'h3C:   res = {1'b1, 5'd21};
      8'h43:   res = {1'b1, 5'd22};
      8'h44:   res = {1'b1, 5'd23};
      8'h4D:   res = {1'b1, 5'd24};
      8'h54:   res = {1'b1, 5'd25};
      8'h5B:   res = {1'b1, 5'd26};
      8'h5D:   res = {1'b1, 5'd27};
      8'h29:   res = {1'b1, 5'd28};
      default: res = {1'b0, 5'd0};
    endcase
    return res;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [28:0] key_state_q, key_state_d;
  logic        ev_valid_q, ev_valid_d;
  logic [4:0]  ev_index_q, ev_index_d;
  logic        ev_pressed_q, ev_pressed_d;
  logic        seq_error_q, seq_error_d;

  logic [5:0]  lookup_s;
  logic        key_hit_s;
  logic [4:0]  key_idx_s;
  logic        key_held_s;

  assign lookup_s   = key_lookup(ps2_byte);
  assign key_hit_s  = lookup_s[5];
  assign key_idx_s  = lookup_s[4:0];
  assign key_held_s = key_state_q[key_idx_s];

  // Next-state, key vector, event and timeout decision for one cycle
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    key_state_d  = key_state_q;
    ev_valid_d   = 1'b0;
    ev_index_d   = ev_index_q;
    ev_pressed_d = ev_pressed_q;
    seq_error_d  = 1'b0;

    if (ps2_byte_valid) begin
      // Any byte restarts the prefix timer; a strobe that arrives in the
      // same cycle as the timeout takes priority over the timeout.
      cnt_d = 16'd0;
      if (ps2_byte == CODE_SELF_TEST) begin
        key_state_d = 29'd0;
        state_d     = ST_IDLE;
      end else if ((ps2_byte == CODE_ERR_LOW) || (ps2_byte == CODE_ERR_HIGH)) begin
        key_state_d = 29'd0;
        state_d     = ST_IDLE;
        seq_error_d = 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (ps2_byte == CODE_BREAK) begin
              state_d = ST_BREAK;
            end else if (ps2_byte == CODE_EXTENDED) begin
              state_d = ST_EXT;
            end else if (key_hit_s) begin
              key_state_d[key_idx_s] = 1'b1;
              if (REPEAT_FILTER && key_held_s) begin
                ev_valid_d = 1'b0;
              end else begin
                ev_valid_d   = 1'b1;
                ev_index_d   = key_idx_s;
                ev_pressed_d = 1'b1;
              end
            end else begin
              state_d = ST_IDLE;
            end
          end
          ST_BREAK: begin
            state_d = ST_IDLE;
            if (key_hit_s) begin
              key_state_d[key_idx_s] = 1'b0;
              if (REPEAT_FILTER && !key_held_s) begin
                ev_valid_d = 1'b0;
              end else begin
                ev_valid_d   = 1'b1;
                ev_index_d   = key_idx_s;
                ev_pressed_d = 1'b0;
              end
            end else begin
              ev_valid_d = 1'b0;
            end
          end
          ST_EXT: begin
            // Extended keys are tracked only far enough to swallow them.
            if (ps2_byte == CODE_BREAK) begin
              state_d = ST_EXT_BREAK;
            end else begin
              state_d = ST_IDLE;
            end
          end
          ST_EXT_BREAK: begin
            state_d = ST_IDLE;
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end else if (state_q != ST_IDLE) begin
      if (cnt_q == TIMEOUT_LAST) begin
        // The prefix was never completed. Abandon it and keep the held keys.
        state_d     = ST_IDLE;
        cnt_d       = 16'd0;
        seq_error_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end else begin
      cnt_d = 16'd0;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 16'd0;
      key_state_q  <= 29'd0;
      ev_valid_q   <= 1'b0;
      ev_index_q   <= 5'd0;
      ev_pressed_q <= 1'b0;
      seq_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      key_state_q  <= key_state_d;
      ev_valid_q   <= ev_valid_d;
      ev_index_q   <= ev_index_d;
      ev_pressed_q <= ev_pressed_d;
      seq_error_q  <= seq_error_d;
    end
  end

  assign key_state         = key_state_q;
  assign key_event_valid   = ev_valid_q;
  assign key_event_index   = ev_index_q;
  assign key_event_pressed = ev_pressed_q;
  assign seq_error         = seq_error_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Testbench for ps2_key_tracker. Directed scenarios are followed by a
// randomized byte stream. Every cycle is compared against a behavioural
// model of the key tracker.
module tb_ps2_key_tracker;

  localparam int T = 50000;

`ifdef KEY_TRACKER_REPEAT_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic [7:0]  ps2_byte;
  logic        ps2_byte_valid;
  logic [28:0] key_state;
  logic        key_event_valid;
  logic [4:0]  key_event_index;
  logic        key_event_pressed;
  logic        seq_error;

  ps2_key_tracker #(.TIMEOUT_CYCLES(T)) dut (
    .CLOCK_50          (clk),
    .resetn            (resetn),
    .ps2_byte          (ps2_byte),
    .ps2_byte_valid    (ps2_byte_valid),
    .key_state         (key_state),
    .key_event_valid   (key_event_valid),
    .key_event_index   (key_event_index),
    .key_event_pressed (key_event_pressed),
    .seq_error         (seq_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] key_codes [29] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
    8'h0E, 8'h4E, 8'h55, 8'h66, 8'h0D, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
    8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D, 8'h54, 8'h5B, 8'h5D, 8'h29};

  // Reference model state: pending prefix (0 none, 1 break, 2 ext, 3 ext+break)
  bit [28:0] m_keys;
  bit        m_ev_v, m_ev_p, m_err;
  bit [4:0]  m_ev_i;
  int        m_pend, m_idle;
  int        n_checks, n_pass;
  int        n_press_ev, n_rel_ev, n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int code_index(input logic [7:0] b);
    for (int i = 0; i < 29; i++) if (key_codes[i] == b) return i;
    return -1;
  endfunction

  // One clock: apply inputs, update model, compare all outputs
  task automatic cyc(input bit rn, input bit v, input logic [7:0] b);
    int idx;
    @(negedge clk);
    resetn = rn; ps2_byte_valid = v; ps2_byte = b;
    @(posedge clk);
    m_ev_v = 1'b0; m_err = 1'b0;
    idx = code_index(b);
    if (!rn) begin
      m_keys = '0; m_ev_i = '0; m_ev_p = 1'b0; m_pend = 0; m_idle = 0;
    end else if (v) begin
      m_idle = 0;
      if (b == 8'hAA) begin
        m_keys = '0; m_pend = 0;
      end else if (b == 8'h00 || b == 8'hFF) begin
        m_keys = '0; m_pend = 0; m_err = 1'b1;
      end else if (m_pend == 1) begin
        m_pend = 0;
        if (idx >= 0) begin
          if (!(FILT && !m_keys[idx])) begin
            m_ev_v = 1'b1; m_ev_i = 5'(idx); m_ev_p = 1'b0;
          end
          m_keys[idx] = 1'b0;
        end
      end else if (m_pend == 2) begin
        m_pend = (b == 8'hF0) ? 3 : 0;
      end else if (m_pend == 3) begin
        m_pend = 0;
      end else if (b == 8'hF0) begin
        m_pend = 1;
      end else if (b == 8'hE0) begin
        m_pend = 2;
      end else if (idx >= 0) begin
        if (!(FILT && m_keys[idx])) begin
          m_ev_v = 1'b1; m_ev_i = 5'(idx); m_ev_p = 1'b1;
        end
        m_keys[idx] = 1'b1;
      end
    end else if (m_pend != 0) begin
      m_idle++;
      if (m_idle == T) begin
        m_pend = 0; m_idle = 0; m_err = 1'b1;
      end
    end
    #1;
    check("key_state", 32'(key_state), 32'(m_keys));
    check("ev_valid", 32'(key_event_valid), 32'(m_ev_v));
    check("ev_index", 32'(key_event_index), 32'(m_ev_i));
    check("ev_pressed", 32'(key_event_pressed), 32'(m_ev_p));
    check("seq_error", 32'(seq_error), 32'(m_err));
    if (key_event_valid && key_event_pressed) n_press_ev++;
    if (key_event_valid && !key_event_pressed) n_rel_ev++;
    if (seq_error) n_err++;
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, 1'b1, b);
  endtask

  initial begin
    int r;
    logic [7:0] b;
    resetn = 1'b0; ps2_byte_valid = 1'b0; ps2_byte = 8'h00;
    n_checks = 0; n_pass = 0;
    m_keys = '0; m_ev_v = 0; m_ev_p = 0; m_ev_i = 0; m_err = 0; m_pend = 0; m_idle = 0;
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    check("reset_state", 32'(key_state), 32'd0);

    // Basic press and release of key 15
    send(8'h15);
    check("t1_press_bit", 32'(key_state[15]), 32'd1);
    check("t1_press_idx", 32'(key_event_index), 32'd15);
    send(8'hF0);
    send(8'h15);
    check("t1_rel_bit", 32'(key_state[15]), 32'd0);
    check("t1_rel_ev", 32'({key_event_valid, key_event_pressed}), 32'b10);

    // Typematic repeats of key 16
    n_press_ev = 0; n_rel_ev = 0;
    send(8'h1D); send(8'h1D); send(8'h1D);
    send(8'hF0); send(8'h1D);
    check("t2_press_cnt", 32'(n_press_ev), FILT ? 32'd1 : 32'd3);
    check("t2_rel_cnt", 32'(n_rel_ev), 32'd1);
    check("t2_bit", 32'(key_state[16]), 32'd0);

    // Extended keys are swallowed
    n_press_ev = 0; n_rel_ev = 0;
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    send(8'h29);
    check("t3_state", 32'(key_state), 32'h1000_0000);
    check("t3_events", 32'(n_press_ev + n_rel_ev), 32'd1);

    // Break prefix timeout keeps held keys
    send(8'h45);
    n_err = 0;
    send(8'hF0);
    for (int i = 0; i < T; i++) cyc(1'b1, 1'b0, 8'h00);
    check("t4_err_cnt", 32'(n_err), 32'd1);
    check("t4_err_last", 32'(seq_error), 32'd1);
    send(8'h45);
    check("t4_bits", 32'(key_state), 32'h1000_0001);
    check("t4_ev", 32'({key_event_valid, key_event_pressed}), FILT ? 32'b00 : 32'b11);

    // Error byte clears, self-test byte does not error
    send(8'h16); send(8'h1E); send(8'h26);
    send(8'hFF);
    check("t5_clear", 32'(key_state), 32'd0);
    check("t5_err", 32'(seq_error), 32'd1);
    send(8'hAA);
    check("t5_aa_err", 32'(seq_error), 32'd0);

    // Reset mid-sequence discards the pending break and the strobed byte
    send(8'h45);
    send(8'hF0);
    cyc(1'b0, 1'b1, 8'h45);
    check("t6_rst_outs", 32'({key_state, key_event_valid, key_event_index, key_event_pressed, seq_error}), 32'd0);
    send(8'h45);
    check("t6_press", 32'({key_event_valid, key_event_pressed, key_event_index}), 32'b1100000);

    // Timeout racing a byte: the byte wins
    send(8'hF0);
    for (int i = 0; i < T - 1; i++) cyc(1'b1, 1'b0, 8'h00);
    send(8'h45);
    check("t7_race_err", 32'(seq_error), 32'd0);
    check("t7_race_rel", 32'(key_state[0]), 32'd0);

    // Randomized stream
    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 45)      b = key_codes[$urandom_range(0, 28)];
      else if (r < 56) b = 8'hF0;
      else if (r < 63) b = 8'hE0;
      else if (r < 65) b = 8'hAA;
      else if (r < 66) b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      else             b = 8'($urandom_range(0, 255));
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 7), b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Consumes the raw byte stream from the PS/2 controller (8-bit data plus one-cycle new-data strobe) and maintains a debounced pressed/released vector for the 29 piano-mapped keys. It decodes set-2 make, break (0xF0 prefix) and extended (0xE0 prefix) sequences. It also emits one-cycle key events for the recorder/playback FSM. It sits directly downstream of the PS/2 controller and replaces ad-hoc scan-code handling in the top level.

## Interface
- TIMEOUT_CYCLES, 50000: max cycles allowed between a prefix byte (0xF0/0xE0) and its follow-up byte; 1 ms at 50 MHz; 16-bit range, must be ≥ 2.
- CLOCK_50  in  1  system clock, all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- ps2_byte  in  8  byte received from the PS/2 controller.
- ps2_byte_valid  in  1  one-cycle strobe; ps2_byte is valid this cycle.
- key_state  out  29  bit i = 1 while key i is held.
- key_event_valid  out  1  one-cycle pulse per accepted press/release.
- key_event_index  out  5  index (0–28) of the event key.
- key_event_pressed  out  1  1 = press, 0 = release; valid with key_event_valid.
- seq_error  out  1  one-cycle pulse on timeout or on a controller error byte.

## Operation
- Index map (index:code): 0:45, 1:16, 2:1E, 3:26, 4:25, 5:2E, 6:36, 7:3D, 8:3E, 9:46, 10:0E (tilde), 11:4E, 12:55, 13:66, 14:0D, 15:15, 16:1D, 17:24, 18:2D, 19:2C, 20:35, 21:3C, 22:43, 23:44, 24:4D, 25:54, 26:5B, 27:5D, 28:29 (space).
- States: IDLE, BREAK, EXT, EXT_BREAK.
- IDLE:
  - 0xF0 → BREAK.
  - 0xE0 → EXT.
  - Mapped code → set bit and emit a press event.
  - Unmapped code → ignored.
- BREAK: mapped code → clear bit and emit a release event. Any byte → IDLE.
- EXT: 0xF0 → EXT_BREAK. Any other byte is consumed without effect → IDLE.
- EXT_BREAK: any byte is consumed without effect → IDLE. Extended keys never touch key_state.
- 0xAA (self-test pass) in any state: clear key_state, → IDLE, no event, no seq_error.
- 0x00 or 0xFF (controller error/overrun) in any state: clear key_state, → IDLE, pulse seq_error.
- A release for a key already clear still emits a release event. key_state is unchanged.
- Timeout: a counter runs only in BREAK/EXT/EXT_BREAK and resets on entry and on every valid byte.
  - Reaching TIMEOUT_CYCLES without a byte → IDLE, seq_error pulse, key_state unchanged.
- ps2_byte is ignored on cycles where ps2_byte_valid = 0.

## Timing
- All outputs are registered. Reset values:
  - key_state = 0.
  - key_event_valid = 0, key_event_index = 0, key_event_pressed = 0.
  - seq_error = 0.
  - State = IDLE, timeout counter = 0.
- Latency: a byte strobed in cycle N updates key_state, key_event_* and the state in cycle N+1.
- key_event_index and key_event_pressed hold their last value when key_event_valid = 0.
- Back-to-back strobes (every cycle) are fully supported; one byte is processed per cycle, with no backpressure.
- If a strobe arrives in the same cycle the timeout would fire, the byte wins. It is processed in the current state and no seq_error is raised.
- resetn low overrides everything, including a byte strobed in the same cycle, which is discarded.
- Reset mid-sequence (e.g. after 0xF0) returns to IDLE; the pending break is lost.

## Configuration
- KEY_TRACKER_REPEAT_FILTER_EN defined: a make code for a key whose bit is already set produces no event. This suppresses typematic repeats. A release of an already-clear key also produces no event.
- Undefined: every mapped make/break emits an event, so typematic repeats appear as repeated press events.
- key_state behaviour is identical in both builds.

## Test plan
- Reset, then strobe 0x15 → cycle+1: key_state[15] = 1, event (15, pressed = 1). Then strobe 0xF0, 0x15 → key_state[15] = 0, event (15, pressed = 0).
- Strobe 0x1D three times, then 0xF0, 0x1D:
  - With filter: one press event.
  - Without filter: three press events.
  - In both builds: one release event and key_state[16] = 0.
- Strobe 0xE0, 0x75, 0xE0, 0xF0, 0x75, then 0x29 → only key_state[28] set; one event (28, 1); no events for the extended bytes.
- Hold keys 0 and 28, strobe 0xF0, then wait 50000 idle cycles → seq_error pulse, state IDLE. Next 0x45 emits a press event; key_state keeps bits 0 and 28.
- Hold 5 keys, strobe 0xFF → key_state = 0, seq_error pulse. Strobe 0xAA → no seq_error.
- Strobe 0xF0, then assert resetn = 0 for one cycle while 0x45 is strobed → all outputs 0. Next 0x45 is treated as a press.
